// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared FSM encoding, forward-select codes and the pipeline bubble instruction.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MD_WAIT   = 2'd1,
        IMEM_WAIT = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: combinational operand forwarding select and load-use detection.
module hazard_fwd_unit
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs1D,
    input  logic [4:0] rs2D,
    input  logic [4:0] rs1E,
    input  logic [4:0] rs2E,
    input  logic [4:0] rdE,
    input  logic [4:0] rdM,
    input  logic [4:0] rdW,
    input  logic       RegWriteE,
    input  logic       LoadE,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       load_use
);

    logic m_ok, w_ok;

    // x0 is hardwired to zero, so a write to it never produces a dependency
    assign m_ok = RegWriteM && rdM != 5'd0;
    assign w_ok = RegWriteW && rdW != 5'd0;

    assign ForwardAE = (m_ok && rdM == rs1E) ? FWD_MEM :
                       (w_ok && rdW == rs1E) ? FWD_WB  : FWD_RF;
    assign ForwardBE = (m_ok && rdM == rs2E) ? FWD_MEM :
                       (w_ok && rdW == rs2E) ? FWD_WB  : FWD_RF;

    assign load_use = LoadE && RegWriteE && rdE != 5'd0 && (rdE == rs1D || rdE == rs2D);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline stall/flush/forward control with mul/div wait, imem wait and perf counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       rs1D,
    input  logic [4:0]       rs2D,
    input  logic [4:0]       rs1E,
    input  logic [4:0]       rs2E,
    input  logic [4:0]       rdE,
    input  logic             RegWriteE,
    input  logic             LoadE,
    input  logic [4:0]       rdM,
    input  logic             RegWriteM,
    input  logic [4:0]       rdW,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             MdE,
    input  logic             md_done,
    input  logic             imem_ready,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             md_start,
    output logic             md_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int TW = MD_TIMEOUT > 1 ? $clog2(MD_TIMEOUT) : 1;

    state_t        state;
    logic [TW-1:0] tmo;
    logic          load_use, md_hold, br, lu, im;

    hazard_fwd_unit u_fwd (
        .rs1D      (rs1D),
        .rs2D      (rs2D),
        .rs1E      (rs1E),
        .rs2E      (rs2E),
        .rdE       (rdE),
        .rdM       (rdM),
        .rdW       (rdW),
        .RegWriteE (RegWriteE),
        .LoadE     (LoadE),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .ForwardAE (ForwardAE),
        .ForwardBE (ForwardBE),
        .load_use  (load_use)
    );

    // Each term is already masked by every higher-priority cause for this cycle
    assign md_hold = state == MD_WAIT && !md_done;
    assign br      = state != MD_WAIT && PCSrcE;
    assign lu      = state == RUN && !PCSrcE && !MdE && load_use;
    assign im      = !imem_ready && !PCSrcE &&
                     (state == IMEM_WAIT || (state == RUN && !MdE && !load_use));

    assign StallF = md_hold | lu | im;
    assign StallD = md_hold | lu;
    assign StallE = md_hold;
    assign FlushD = br | im;
    assign FlushE = br | lu;
    assign FlushM = md_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            tmo       <= '0;
            md_start  <= 1'b0;
            md_err    <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            md_start <= 1'b0;
            md_err   <= 1'b0;
            if (StallF && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (br && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
            case (state)
                RUN: begin
                    if (!PCSrcE) begin
                        if (MdE) begin
                            state    <= MD_WAIT;
                            tmo      <= '0;
                            md_start <= 1'b1;
                        end else if (!load_use && !imem_ready) begin
                            state <= IMEM_WAIT;
                        end
                    end
                end
                MD_WAIT: begin
                    if (md_done) begin
                        state <= RUN;
                    end else if (tmo == TW'(MD_TIMEOUT - 1)) begin
                        md_err <= 1'b1;
                        state  <= RUN;
                    end else begin
                        tmo <= tmo + TW'(1);
                    end
                end
                IMEM_WAIT: if (!PCSrcE && imem_ready) state <= RUN;
                default:   state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: scoreboard bench; a behavioural model queues per-cycle expectations, a monitor compares.
module tb_hazard_ctrl;

    localparam int TMO  = 8;
    localparam int CW   = 5;
    localparam int MAXC = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic RegWriteE, LoadE, RegWriteM, RegWriteW, PCSrcE, MdE, md_done, imem_ready;
    logic StallF, StallD, StallE, FlushD, FlushE, FlushM, md_start, md_err;
    logic [1:0] ForwardAE, ForwardBE;
    logic [CW-1:0] stall_cnt, flush_cnt;

    typedef struct packed {
        logic [11:0]   ctl;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } exp_t;

    exp_t q[$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;

    bit m_md, m_im, m_start, m_err;
    int m_age, m_sc, m_fc;

    always #5 clk = ~clk;

    hazard_ctrl #(.MD_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rs1D       (rs1D),
        .rs2D       (rs2D),
        .rs1E       (rs1E),
        .rs2E       (rs2E),
        .rdE        (rdE),
        .RegWriteE  (RegWriteE),
        .LoadE      (LoadE),
        .rdM        (rdM),
        .RegWriteM  (RegWriteM),
        .rdW        (rdW),
        .RegWriteW  (RegWriteW),
        .PCSrcE     (PCSrcE),
        .MdE        (MdE),
        .md_done    (md_done),
        .imem_ready (imem_ready),
        .StallF     (StallF),
        .StallD     (StallD),
        .StallE     (StallE),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .FlushM     (FlushM),
        .ForwardAE  (ForwardAE),
        .ForwardBE  (ForwardBE),
        .md_start   (md_start),
        .md_err     (md_err),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    function automatic logic [1:0] fwd(input logic [4:0] rs);
        if (RegWriteM && rdM != 0 && rdM == rs) return 2'b10;
        if (RegWriteW && rdW != 0 && rdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic set_idle();
        {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW} = '0;
        {RegWriteE, LoadE, RegWriteM, RegWriteW, PCSrcE, MdE, md_done} = '0;
        imem_ready = 1'b1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // Reference model: the pipeline's condition this cycle, taken in priority order
    task automatic do_cycle();
        bit sf = 0, sd = 0, se = 0, fd = 0, fe = 0, fm = 0;
        bit n_md, n_im, n_start = 0, n_err = 0, lu;
        int n_age, n_fc;
        exp_t e;
        if (!rst_n) begin
            m_md = 0; m_im = 0; m_start = 0; m_err = 0; m_age = 0; m_sc = 0; m_fc = 0;
        end
        n_md = m_md; n_im = m_im; n_age = m_age; n_fc = m_fc;
        lu = LoadE && RegWriteE && rdE != 0 && (rdE == rs1D || rdE == rs2D);
        if (m_md) begin
            if (md_done) n_md = 0;
            else begin
                sf = 1; sd = 1; se = 1; fm = 1;
                if (m_age == TMO - 1) begin n_err = 1; n_md = 0; end
                else n_age = m_age + 1;
            end
        end else if (PCSrcE) begin
            fd = 1; fe = 1;
            n_fc = m_fc < MAXC ? m_fc + 1 : MAXC;
        end else if (!m_im && MdE) begin
            n_start = 1; n_md = 1; n_age = 0;
        end else if (!m_im && lu) begin
            sf = 1; sd = 1; fe = 1;
        end else if (!imem_ready) begin
            sf = 1; fd = 1; n_im = 1;
        end else begin
            n_im = 0;
        end
        e.ctl = {sf, sd, se, fd, fe, fm, fwd(rs1E), fwd(rs2E), m_start, m_err};
        e.sc  = CW'(m_sc);
        e.fc  = CW'(m_fc);
        q.push_back(e);
        if (rst_n) begin
            m_md = n_md; m_im = n_im; m_age = n_age; m_fc = n_fc;
            m_start = n_start; m_err = n_err;
            m_sc = (m_sc + int'(sf) > MAXC) ? MAXC : m_sc + int'(sf);
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [11:0] got;
        if (q.size() != 0) begin
            e = q.pop_front();
            got = {StallF, StallD, StallE, FlushD, FlushE, FlushM, ForwardAE, ForwardBE, md_start, md_err};
            tests++;
            cyc++;
            if (got !== e.ctl || stall_cnt !== e.sc || flush_cnt !== e.fc) begin
                fails++;
                $display("FAIL cycle %0d outputs: got ctl=%b sc=%0d fc=%0d, expected ctl=%b sc=%0d fc=%0d",
                         cyc, got, stall_cnt, flush_cnt, e.ctl, e.sc, e.fc);
            end
        end
    end

    initial begin
        set_idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        do_cycle();
        chk("reset_stall_cnt", 32'(stall_cnt), 0);
        chk("reset_md_start", 32'(md_start), 0);
        rst_n = 1'b1;
        do_cycle();
        // load-use on rs1D
        rdE = 5; LoadE = 1; RegWriteE = 1; rs1D = 5;
        #1 chk("loaduse_stallF", 32'(StallF), 1);
        do_cycle();
        set_idle();
        chk("loaduse_stall_cnt", 32'(stall_cnt), 1);
        rdE = 0; rs1D = 0; LoadE = 1; RegWriteE = 1;
        #1 chk("x0_no_stall", 32'(StallF), 0);
        do_cycle();
        set_idle();
        // forwarding priority and x0
        rdM = 3; RegWriteM = 1; rdW = 3; RegWriteW = 1; rs1E = 3;
        #1 chk("fwdA_mem", 32'(ForwardAE), 2);
        do_cycle();
        RegWriteM = 0;
        #1 chk("fwdA_wb", 32'(ForwardAE), 1);
        do_cycle();
        rdM = 0; RegWriteM = 1; rdW = 0;
        #1 chk("fwdA_x0", 32'(ForwardAE), 0);
        do_cycle();
        rs2E = 3; rdM = 3;
        #1 chk("fwdB_mem", 32'(ForwardBE), 2);
        do_cycle();
        set_idle();
        // branch overrides load-use
        rdE = 5; LoadE = 1; RegWriteE = 1; rs1D = 5; PCSrcE = 1;
        #1 chk("branch_stallF", 32'(StallF), 0);
        chk("branch_flushD", 32'(FlushD), 1);
        do_cycle();
        set_idle();
        chk("branch_flush_cnt", 32'(flush_cnt), 1);
        // mul/div completing early
        MdE = 1;
        do_cycle();
        chk("md_start_pulse", 32'(md_start), 1);
        repeat (5) do_cycle();
        md_done = 1;
        #1 chk("md_release", 32'(StallE), 0);
        do_cycle();
        set_idle();
        chk("md_start_once", 32'(md_start), 0);
        // md_done on the timeout cycle wins
        MdE = 1;
        do_cycle();
        MdE = 0;
        repeat (TMO - 1) do_cycle();
        md_done = 1;
        do_cycle();
        md_done = 0;
        chk("done_beats_timeout", 32'(md_err), 0);
        // timeout
        MdE = 1;
        do_cycle();
        MdE = 0;
        repeat (TMO) do_cycle();
        chk("md_err_pulse", 32'(md_err), 1);
        chk("md_err_released", 32'(StallE), 0);
        do_cycle();
        // imem wait, with a branch inside it
        imem_ready = 0;
        repeat (3) do_cycle();
        imem_ready = 1;
        do_cycle();
        imem_ready = 0;
        do_cycle();
        PCSrcE = 1;
        do_cycle();
        PCSrcE = 0;
        do_cycle();
        imem_ready = 1;
        do_cycle();
        // reset during MD_WAIT
        MdE = 1;
        repeat (4) do_cycle();
        rst_n = 0;
        MdE = 0;
        #1 chk("reset_md_StallE", 32'(StallE), 0);
        do_cycle();
        chk("reset_md_stall_cnt", 32'(stall_cnt), 0);
        chk("reset_md_flush_cnt", 32'(flush_cnt), 0);
        rst_n = 1;
        // counter saturation
        imem_ready = 0;
        repeat (MAXC + 4) do_cycle();
        chk("stall_cnt_saturates", 32'(stall_cnt), MAXC);
        imem_ready = 1;
        do_cycle();
        // randomized traffic with dense register collisions
        for (int i = 0; i < 600; i++) begin
            rs1D = 5'($urandom_range(0, 3)); rs2D = 5'($urandom_range(0, 3));
            rs1E = 5'($urandom_range(0, 3)); rs2E = 5'($urandom_range(0, 3));
            rdE  = 5'($urandom_range(0, 3)); rdM  = 5'($urandom_range(0, 3));
            rdW  = 5'($urandom_range(0, 3));
            RegWriteE = 1'($urandom_range(0, 1)); LoadE = 1'($urandom_range(0, 1));
            RegWriteM = 1'($urandom_range(0, 1)); RegWriteW = 1'($urandom_range(0, 1));
            PCSrcE = $urandom_range(0, 7) == 0;
            MdE = $urandom_range(0, 9) == 0;
            md_done = $urandom_range(0, 5) == 0;
            imem_ready = $urandom_range(0, 3) != 0;
            rst_n = $urandom_range(0, 99) != 0;
            do_cycle();
        end
        set_idle();
        rst_n = 1;
        repeat (2) do_cycle();
        chk("scoreboard_drained", 32'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
